// File: rtl/axi4l_master_pkg.sv
// Shared definitions for the AXI4-Lite master: FSM state encoding,
// response and protection constants, and a response decode helper.
package axi4l_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    // Any response other than OKAY is reported to the core as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4l_tmo_cnt.sv
// Busy-cycle counter for the AXI4-Lite master. Counts every cycle the master
// is out of IDLE and flags expiry in the cycle the count reaches the limit.
module axi4l_tmo_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_reg;

    // Expiry fires on the TIMEOUT_CYCLES-th consecutive busy cycle.
    assign expired = busy && (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    // Count busy cycles; restart from zero whenever the master is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (!busy) begin
            cnt_reg <= '0;
        end else if (!expired) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/axi4l_master.sv
// Single-outstanding AXI4-Lite master bridging a simple valid/ready core
// request port to the five AXI4-Lite channels. Completion is reported as a
// one-cycle rsp_valid pulse. Optional busy timeout: define AXI4L_TIMEOUT_EN.
module axi4l_master
    import axi4l_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // core request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    // core response
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    // AXI4-Lite write address / data / response
    output logic [31:0] m_awaddr,
    output logic [2:0]  m_awprot,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    // AXI4-Lite read address / data
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        awvalid_reg;
    logic        wvalid_reg;
    logic        bready_reg;
    logic        arvalid_reg;
    logic        rready_reg;
    logic        rsp_valid_reg;
    logic        rsp_err_reg;
    logic [31:0] rsp_rdata_reg;
    logic        timeout;

`ifdef AXI4L_TIMEOUT_EN
    axi4l_tmo_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .busy    (state_reg != ST_IDLE),
        .expired (timeout)
    );
`else
    // No abort path: the master waits on the slave indefinitely.
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
`endif

    assign req_ready = (state_reg == ST_IDLE);

    assign m_awaddr  = addr_reg;
    assign m_araddr  = addr_reg;
    assign m_wdata   = wdata_reg;
    assign m_wstrb   = wstrb_reg;
    assign m_awprot  = PROT_DEFAULT;
    assign m_arprot  = PROT_DEFAULT;
    assign m_awvalid = awvalid_reg;
    assign m_wvalid  = wvalid_reg;
    assign m_bready  = bready_reg;
    assign m_arvalid = arvalid_reg;
    assign m_rready  = rready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;

    // Transaction FSM with registered channel handshakes and response pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            if (timeout) begin
                // Abort: drop every outstanding valid/ready and report an error.
                awvalid_reg   <= 1'b0;
                wvalid_reg    <= 1'b0;
                bready_reg    <= 1'b0;
                arvalid_reg   <= 1'b0;
                rready_reg    <= 1'b0;
                state_reg     <= ST_IDLE;
                rsp_valid_reg <= 1'b1;
                rsp_err_reg   <= 1'b1;
                rsp_rdata_reg <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (req_valid) begin
                            addr_reg  <= req_addr;
                            wdata_reg <= req_wdata;
                            wstrb_reg <= req_wstrb;
                            if (req_we) begin
                                awvalid_reg <= 1'b1;
                                wvalid_reg  <= 1'b1;
                                state_reg   <= ST_WADDR;
                            end else begin
                                arvalid_reg <= 1'b1;
                                state_reg   <= ST_RADDR;
                            end
                        end
                    end
                    ST_WADDR: begin
                        // AW and W complete independently; move on once both are done.
                        if (m_awready) awvalid_reg <= 1'b0;
                        if (m_wready)  wvalid_reg  <= 1'b0;
                        if ((!awvalid_reg || m_awready) && (!wvalid_reg || m_wready)) begin
                            bready_reg <= 1'b1;
                            state_reg  <= ST_WRESP;
                        end
                    end
                    ST_WRESP: begin
                        if (m_bvalid) begin
                            bready_reg    <= 1'b0;
                            state_reg     <= ST_IDLE;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= resp_is_err(m_bresp);
                            rsp_rdata_reg <= '0;
                        end
                    end
                    ST_RADDR: begin
                        if (m_arready) begin
                            arvalid_reg <= 1'b0;
                            rready_reg  <= 1'b1;
                            state_reg   <= ST_RDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (m_rvalid) begin
                            rready_reg    <= 1'b0;
                            state_reg     <= ST_IDLE;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= resp_is_err(m_rresp);
                            rsp_rdata_reg <= m_rdata;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi4l_master.sv
// Directed testbench for axi4l_master. Inputs are driven and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_axi4l_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;

    int checks   = 0;
    int failures = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0;

    axi4l_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    // Handshake counters observed on the bus.
    always @(posedge clk) begin
        if (m_awvalid && m_awready) aw_hs <= aw_hs + 1;
        if (m_wvalid && m_wready)   w_hs  <= w_hs + 1;
        if (m_bvalid && m_bready)   b_hs  <= b_hs + 1;
    end

    task automatic slave_idle();
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00;
        m_arready = 0; m_rvalid = 0; m_rdata = 32'h0; m_rresp = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        slave_idle();
        @(negedge clk); @(negedge clk);
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000000",
                {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err});
        end
        checks++;
        if ({rsp_rdata, m_awaddr, m_wdata} !== 96'h0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", rsp_rdata, m_awaddr, m_wdata);
        end
        checks++;
        if (req_ready !== 1'b1 || m_awprot !== 3'b000 || m_arprot !== 3'b000) begin
            failures++; $display("FAIL reset_ready_prot got=%b/%b/%b exp=1/000/000", req_ready, m_awprot, m_arprot);
        end
        rst_n = 1;
        @(negedge clk);
        $display("txn reset done");
    endtask

    task automatic test_zero_wait_write();
        int aw0, w0, b0;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        m_awready = 1; m_wready = 1; m_bvalid = 1; m_bresp = 2'b00;
        req_valid = 1; req_we = 1; req_addr = 32'h0000_0010; req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL zw_accept got=%b exp=1", req_ready); end
        @(negedge clk); // cycle 1
        req_valid = 0;
        checks++;
        if (m_awvalid !== 1 || m_wvalid !== 1 || m_awaddr !== 32'h10 || m_wdata !== 32'hDEAD_BEEF || m_wstrb !== 4'hF) begin
            failures++; $display("FAIL zw_aw_w got=%b%b %h %h %h exp=11 00000010 deadbeef f",
                m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb);
        end
        @(negedge clk); // cycle 2
        checks++;
        if (m_awvalid !== 0 || m_wvalid !== 0 || m_bready !== 1 || rsp_valid !== 0) begin
            failures++; $display("FAIL zw_bphase got=aw%b w%b b%b rsp%b exp=aw0 w0 b1 rsp0", m_awvalid, m_wvalid, m_bready, rsp_valid);
        end
        @(negedge clk); // cycle 3
        checks++;
        if (rsp_valid !== 1 || rsp_err !== 0 || rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL zw_rsp got=%b %b %h exp=1 0 00000000", rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if (aw_hs - aw0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
            failures++; $display("FAIL zw_hs_count got=%0d/%0d/%0d exp=1/1/1", aw_hs - aw0, w_hs - w0, b_hs - b0);
        end
        @(negedge clk); // cycle 4
        slave_idle();
        checks++;
        if (rsp_valid !== 0) begin failures++; $display("FAIL zw_pulse_width got=%b exp=0", rsp_valid); end
        $display("txn write addr=00000010 data=deadbeef rsp_err=%b", rsp_err);
    endtask

    task automatic test_wait_write();
        int aw0, w0, b0;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        m_awready = 0; m_wready = 1; m_bvalid = 0;
        req_valid = 1; req_we = 1; req_addr = 32'h0000_0040; req_wdata = 32'hCAFE_0001; req_wstrb = 4'h3;
        @(negedge clk); // cycle 1: W handshake
        req_valid = 0;
        @(negedge clk); // cycle 2
        checks++;
        if (m_wvalid !== 0 || m_awvalid !== 1 || m_awaddr !== 32'h40 || m_bready !== 0) begin
            failures++; $display("FAIL ww_hold got=w%b aw%b %h b%b exp=w0 aw1 00000040 b0", m_wvalid, m_awvalid, m_awaddr, m_bready);
        end
        @(negedge clk); // cycle 3: AW handshake
        m_awready = 1; m_wready = 0;
        checks++;
        if (m_awvalid !== 1 || m_wvalid !== 0) begin
            failures++; $display("FAIL ww_aw_still got=aw%b w%b exp=aw1 w0", m_awvalid, m_wvalid);
        end
        @(negedge clk); // cycle 4
        m_awready = 0; m_bvalid = 1; m_bresp = 2'b00;
        checks++;
        if (m_awvalid !== 0 || m_bready !== 1) begin
            failures++; $display("FAIL ww_bphase got=aw%b b%b exp=aw0 b1", m_awvalid, m_bready);
        end
        @(negedge clk); // cycle 5
        m_bvalid = 0;
        checks++;
        if (rsp_valid !== 1 || rsp_err !== 0) begin
            failures++; $display("FAIL ww_rsp got=%b %b exp=1 0", rsp_valid, rsp_err);
        end
        @(negedge clk);
        checks++;
        if (aw_hs - aw0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
            failures++; $display("FAIL ww_hs_count got=%0d/%0d/%0d exp=1/1/1", aw_hs - aw0, w_hs - w0, b_hs - b0);
        end
        slave_idle();
        $display("txn write addr=00000040 awready-late rsp_err=%b", rsp_err);
    endtask

    task automatic test_read_error();
        m_arready = 1;
        req_valid = 1; req_we = 0; req_addr = 32'h0000_0004;
        @(negedge clk); // cycle 1: AR handshake
        req_valid = 0;
        checks++;
        if (m_arvalid !== 1 || m_araddr !== 32'h4 || m_awvalid !== 0) begin
            failures++; $display("FAIL rd_ar got=%b %h aw%b exp=1 00000004 aw0", m_arvalid, m_araddr, m_awvalid);
        end
        @(negedge clk); // cycle 2 (wait 1)
        m_arready = 0;
        checks++;
        if (m_arvalid !== 0 || m_rready !== 1) begin
            failures++; $display("FAIL rd_rphase got=ar%b r%b exp=ar0 r1", m_arvalid, m_rready);
        end
        @(negedge clk); // cycle 3 (wait 2)
        @(negedge clk); // cycle 4 (wait 3)
        checks++;
        if (m_rready !== 1 || rsp_valid !== 0) begin
            failures++; $display("FAIL rd_waiting got=r%b rsp%b exp=r1 rsp0", m_rready, rsp_valid);
        end
        @(negedge clk); // cycle 5: R handshake
        m_rvalid = 1; m_rdata = 32'h1234_5678; m_rresp = 2'b10;
        @(negedge clk); // cycle 6
        slave_idle();
        checks++;
        if (rsp_valid !== 1 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1) begin
            failures++; $display("FAIL rd_rsp got=%b %h %b exp=1 12345678 1", rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk); // cycle 7
        checks++;
        if (rsp_valid !== 0 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1 || m_rready !== 0) begin
            failures++; $display("FAIL rd_hold got=%b %h %b r%b exp=0 12345678 1 r0", rsp_valid, rsp_rdata, rsp_err, m_rready);
        end
        $display("txn read addr=00000004 rdata=%h rsp_err=%b", rsp_rdata, rsp_err);
    endtask

`ifdef AXI4L_TIMEOUT_EN
    task automatic test_timeout();
        m_arready = 0;
        req_valid = 1; req_we = 0; req_addr = 32'h0000_0080;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            req_valid = 0;
            checks++;
            if (m_arvalid !== 1 || rsp_valid !== 0) begin
                failures++; $display("FAIL tmo_busy cycle=%0d got=ar%b rsp%b exp=ar1 rsp0", i, m_arvalid, rsp_valid);
            end
        end
        @(negedge clk); // cycle 9
        checks++;
        if (m_arvalid !== 0 || rsp_valid !== 1 || rsp_err !== 1 || rsp_rdata !== 32'h0 || req_ready !== 1) begin
            failures++; $display("FAIL tmo_abort got=ar%b rsp%b err%b %h rdy%b exp=ar0 rsp1 err1 00000000 rdy1",
                m_arvalid, rsp_valid, rsp_err, rsp_rdata, req_ready);
        end
        @(negedge clk);
        $display("txn read addr=00000080 timeout rsp_err=%b", rsp_err);
    endtask
`else
    task automatic test_no_timeout();
        m_arready = 0;
        req_valid = 1; req_we = 0; req_addr = 32'h0000_0080;
        @(negedge clk);
        req_valid = 0;
        repeat (20) @(negedge clk);
        checks++;
        if (m_arvalid !== 1 || rsp_valid !== 0 || req_ready !== 0) begin
            failures++; $display("FAIL notmo_wait got=ar%b rsp%b rdy%b exp=ar1 rsp0 rdy0", m_arvalid, rsp_valid, req_ready);
        end
        m_arready = 1; m_rvalid = 1; m_rdata = 32'h0000_0055; m_rresp = 2'b00;
        @(negedge clk);
        @(negedge clk);
        slave_idle();
        checks++;
        if (rsp_valid !== 1 || rsp_rdata !== 32'h55 || rsp_err !== 0) begin
            failures++; $display("FAIL notmo_rsp got=%b %h %b exp=1 00000055 0", rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        $display("txn read addr=00000080 slow-slave rdata=%h", rsp_rdata);
    endtask
`endif

    task automatic test_back_to_back();
        m_arready = 1; m_rvalid = 1; m_rdata = 32'hA5A5_0001; m_rresp = 2'b00;
        m_awready = 1; m_wready = 1; m_bvalid = 1; m_bresp = 2'b11;
        req_valid = 1; req_we = 0; req_addr = 32'h0000_0020;
        @(negedge clk); // cycle 1: read in RADDR, write request now pending
        req_we = 1; req_addr = 32'h0000_0024; req_wdata = 32'h0BAD_F00D; req_wstrb = 4'hC;
        checks++;
        if (req_ready !== 0 || m_arvalid !== 1) begin
            failures++; $display("FAIL b2b_busy got=rdy%b ar%b exp=rdy0 ar1", req_ready, m_arvalid);
        end
        @(negedge clk); // cycle 2: R handshake
        @(negedge clk); // cycle 3: read response, write accepted
        checks++;
        if (rsp_valid !== 1 || req_ready !== 1 || rsp_rdata !== 32'hA5A5_0001 || rsp_err !== 0) begin
            failures++; $display("FAIL b2b_overlap got=rsp%b rdy%b %h err%b exp=rsp1 rdy1 a5a50001 err0",
                rsp_valid, req_ready, rsp_rdata, rsp_err);
        end
        @(negedge clk); // cycle 4
        req_valid = 0;
        checks++;
        if (m_awvalid !== 1 || m_awaddr !== 32'h24 || m_wstrb !== 4'hC || m_arvalid !== 0) begin
            failures++; $display("FAIL b2b_write got=aw%b %h %h ar%b exp=aw1 00000024 c ar0", m_awvalid, m_awaddr, m_wstrb, m_arvalid);
        end
        @(negedge clk); // cycle 5
        @(negedge clk); // cycle 6
        checks++;
        if (rsp_valid !== 1 || rsp_rdata !== 32'h0 || rsp_err !== 1) begin
            failures++; $display("FAIL b2b_wrsp got=%b %h %b exp=1 00000000 1", rsp_valid, rsp_rdata, rsp_err);
        end
        slave_idle();
        @(negedge clk);
        $display("txn read 00000020 then write 00000024 back-to-back");
    endtask

    task automatic test_reset_mid();
        m_awready = 1; m_wready = 1; m_bvalid = 0;
        req_valid = 1; req_we = 1; req_addr = 32'h0000_0100; req_wdata = 32'h7777_8888; req_wstrb = 4'hF;
        @(negedge clk); // cycle 1
        req_valid = 0;
        @(negedge clk); // cycle 2: WRESP
        checks++;
        if (m_bready !== 1 || req_ready !== 0) begin
            failures++; $display("FAIL rm_in_wresp got=b%b rdy%b exp=b1 rdy0", m_bready, req_ready);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err} !== 7'b0 || req_ready !== 1) begin
            failures++; $display("FAIL rm_async got=%b rdy%b exp=0000000 rdy1",
                {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err}, req_ready);
        end
        checks++;
        if ({m_awaddr, m_wdata, m_wstrb, rsp_rdata} !== 100'h0) begin
            failures++; $display("FAIL rm_regs got=%h %h %h %h exp=0", m_awaddr, m_wdata, m_wstrb, rsp_rdata);
        end
        @(negedge clk);
        rst_n = 1;
        m_bvalid = 1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1 || rsp_valid !== 0 || m_bready !== 0) begin
            failures++; $display("FAIL rm_after got=rdy%b rsp%b b%b exp=rdy1 rsp0 b0", req_ready, rsp_valid, m_bready);
        end
        slave_idle();
        $display("txn write 00000100 interrupted by reset");
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_write();
        test_read_error();
`ifdef AXI4L_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
